// File: rtl/dlsc_pcie_outbound_read_req_tagged_if.sv
// rtl/dlsc_pcie_outbound_read_req_tagged_if.sv - AXI read command, TLP header and tag-return bundle
interface dlsc_pcie_outbound_read_req_tagged_if #(
  parameter int ADDR = 32,
  parameter int LEN  = 8,
  parameter int ID   = 4,
  parameter int TAGS = 8
);
  localparam int TAGB = $clog2(TAGS);

  logic              axi_ar_ready;
  logic              axi_ar_valid;
  logic [ADDR-1:0]   axi_ar_addr;
  logic [LEN-1:0]    axi_ar_len;
  logic [ID-1:0]     axi_ar_id;
  logic [2:0]        max_read_request;

  logic              tlp_h_ready;
  logic              tlp_h_valid;
  logic [ADDR-3:0]   tlp_h_addr;
  logic [9:0]        tlp_h_len;
  logic [TAGB-1:0]   tlp_h_tag;
  logic [ID-1:0]     tlp_h_id;
  logic              tlp_h_last;

  logic              tag_free_valid;
  logic [TAGB-1:0]   tag_free;
  logic [TAGB:0]     tags_outstanding;

  // master: the request generator; slave: command source, header sink and completion path
  modport master (
    output axi_ar_ready,
    input  axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_id, max_read_request,
    input  tlp_h_ready,
    output tlp_h_valid, tlp_h_addr, tlp_h_len, tlp_h_tag, tlp_h_id, tlp_h_last,
    input  tag_free_valid, tag_free,
    output tags_outstanding
  );

  modport slave (
    input  axi_ar_ready,
    output axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_id, max_read_request,
    output tlp_h_ready,
    input  tlp_h_valid, tlp_h_addr, tlp_h_len, tlp_h_tag, tlp_h_id, tlp_h_last,
    output tag_free_valid, tag_free,
    input  tags_outstanding
  );
endinterface

// File: rtl/dlsc_pcie_outbound_read_req_tagged.sv
// rtl/dlsc_pcie_outbound_read_req_tagged.sv - AXI read to tagged PCIe Memory Read header splitter
module dlsc_pcie_outbound_read_req_tagged #(
  parameter int ADDR     = 32,
  parameter int LEN      = 8,
  parameter int ID       = 4,
  parameter int TAGS     = 8,
  parameter int MAX_SIZE = 512
) (
  input logic clk,
  input logic rst_n,
  dlsc_pcie_outbound_read_req_tagged_if.master bus
);
  localparam int TAGB = $clog2(TAGS);
  localparam int AW   = ADDR - 2;
  localparam logic [10:0] MAX_DW = 11'(MAX_SIZE / 4);

  typedef enum logic [0:0] {ST_IDLE, ST_SPLIT} state_t;

  state_t          state_q, state_d;
  logic            ar_ready_q, ar_ready_d;
  logic [AW-1:0]   addr_q;
  logic [10:0]     remaining_q;
  logic [ID-1:0]   id_q;
  logic [10:0]     max_len_q;

  logic            h_valid_q;
  logic [AW-1:0]   h_addr_q;
  logic [9:0]      h_len_q;
  logic [TAGB-1:0] h_tag_q;
  logic [ID-1:0]   h_id_q;
  logic            h_last_q;

  logic [TAGS-1:0] alloc_q, alloc_d;
  logic [TAGB-1:0] free_idx;
  logic            any_free;
  logic [TAGB:0]   alloc_cnt;

  logic [10:0]     mrr_dw, max_len_in, boundary, piece;
  logic            ar_fire, h_accept, load;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^bus.axi_ar_addr[1:0];

  assign ar_fire  = (state_q == ST_IDLE) && ar_ready_q && bus.axi_ar_valid;
  assign h_accept = h_valid_q && bus.tlp_h_ready;
  assign any_free = ~&alloc_q;
  assign load     = (state_q == ST_SPLIT) && (remaining_q != 11'd0) &&
                    (!h_valid_q || h_accept) && any_free;

  always_comb begin
    mrr_dw = 11'd32;
    if (bus.max_read_request <= 3'd5)
      mrr_dw = 11'd32 << bus.max_read_request;
    max_len_in = (mrr_dw < MAX_DW) ? mrr_dw : MAX_DW;
  end

  // DW address bits [9:0] are byte address bits [11:2]: distance to the next 4KB page
  always_comb begin
    boundary = 11'd1024 - {1'b0, addr_q[9:0]};
    piece    = remaining_q;
    if (max_len_q < piece) piece = max_len_q;
    if (boundary < piece)  piece = boundary;
  end

  // Lowest-index free tag, chosen from the registered map only
  always_comb begin
    free_idx = '0;
    for (int i = TAGS - 1; i >= 0; i--)
      if (!alloc_q[i]) free_idx = TAGB'(i);
  end

  always_comb begin
    alloc_d = alloc_q;
    if (bus.tag_free_valid) alloc_d[bus.tag_free] = 1'b0;
    if (load)               alloc_d[free_idx]     = 1'b1;
  end

  always_comb begin
    alloc_cnt = '0;
    for (int i = 0; i < TAGS; i++)
      alloc_cnt = alloc_cnt + (TAGB + 1)'(alloc_q[i]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_fire) state_d = ST_SPLIT;
      ST_SPLIT: if (remaining_q == 11'd0 && (!h_valid_q || h_accept)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ar_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ar_ready_q  <= 1'b0;
      h_valid_q   <= 1'b0;
      alloc_q     <= '0;
      remaining_q <= 11'd0;
    end else begin
      state_q    <= state_d;
      ar_ready_q <= ar_ready_d;
      alloc_q    <= alloc_d;
      if (ar_fire)
        remaining_q <= 11'(bus.axi_ar_len) + 11'd1;
      else if (load)
        remaining_q <= remaining_q - piece;
      if (load)
        h_valid_q <= 1'b1;
      else if (h_accept)
        h_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_fire) begin
      addr_q    <= bus.axi_ar_addr[ADDR-1:2];
      id_q      <= bus.axi_ar_id;
      max_len_q <= max_len_in;
    end else if (load) begin
      addr_q <= addr_q + AW'(piece);
    end
    if (load) begin
      h_addr_q <= addr_q;
      h_len_q  <= piece[9:0];
      h_tag_q  <= free_idx;
      h_id_q   <= id_q;
      h_last_q <= (piece == remaining_q);
    end
  end

  assign bus.axi_ar_ready     = ar_ready_q;
  assign bus.tlp_h_valid      = h_valid_q;
  assign bus.tlp_h_addr       = h_addr_q;
  assign bus.tlp_h_len        = h_len_q;
  assign bus.tlp_h_tag        = h_tag_q;
  assign bus.tlp_h_id         = h_id_q;
  assign bus.tlp_h_last       = h_last_q;
  assign bus.tags_outstanding = alloc_cnt;
endmodule

// File: tb/tb_dlsc_pcie_outbound_read_req_tagged.sv
// tb/tb_dlsc_pcie_outbound_read_req_tagged.sv - directed bench for the tagged read request splitter
module tb_dlsc_pcie_outbound_read_req_tagged;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dlsc_pcie_outbound_read_req_tagged_if #(.ADDR(32), .LEN(8), .ID(4), .TAGS(8)) bus ();

  dlsc_pcie_outbound_read_req_tagged #(
    .ADDR(32), .LEN(8), .ID(4), .TAGS(8), .MAX_SIZE(512)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // {valid, addr_dw, len, tag, id, last}
  logic [48:0] got, exp;
  assign got = {bus.tlp_h_valid, bus.tlp_h_addr, bus.tlp_h_len, bus.tlp_h_tag, bus.tlp_h_id, bus.tlp_h_last};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id, input logic [2:0] m);
    int n;
    n = 0;
    bus.axi_ar_addr = a;
    bus.axi_ar_len = l;
    bus.axi_ar_id = id;
    bus.max_read_request = m;
    bus.axi_ar_valid = 1'b1;
    while (bus.axi_ar_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL ar_accept_timeout got_ready=%b required=1", bus.axi_ar_ready);
    end
    tick();
    bus.axi_ar_valid = 1'b0;
  endtask

  task automatic free_all();
    for (int t = 0; t < 8; t++) begin
      bus.tag_free_valid = 1'b1;
      bus.tag_free = 3'(t);
      tick();
    end
    bus.tag_free_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.axi_ar_valid = 1'b0;
    bus.axi_ar_addr = '0;
    bus.axi_ar_len = '0;
    bus.axi_ar_id = '0;
    bus.max_read_request = 3'd0;
    bus.tlp_h_ready = 1'b0;
    bus.tag_free_valid = 1'b0;
    bus.tag_free = '0;
    tick();
    tick();
    checks++;
    if (bus.axi_ar_ready !== 1'b0) begin failures++; $display("FAIL reset_ar_ready got=%b required=0", bus.axi_ar_ready); end
    checks++;
    if (bus.tlp_h_valid !== 1'b0) begin failures++; $display("FAIL reset_h_valid got=%b required=0", bus.tlp_h_valid); end
    checks++;
    if (bus.tags_outstanding !== 4'd0) begin failures++; $display("FAIL reset_outstanding got=%0d required=0", bus.tags_outstanding); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.axi_ar_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ar_ready got=%b required=1", bus.axi_ar_ready); end
  endtask

  task automatic test_single();
    bus.tlp_h_ready = 1'b0;
    send_cmd(32'h1000, 8'd31, 4'h1, 3'd0);
    checks++;
    if (bus.tlp_h_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b required=0", bus.tlp_h_valid); end
    tick();
    exp = {1'b1, 30'h400, 10'd32, 3'd0, 4'h1, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL single_hdr got=%h required=%h", got, exp); end
    bus.tlp_h_ready = 1'b1;
    tick();
    bus.tlp_h_ready = 1'b0;
    checks++;
    if ({bus.tlp_h_valid, bus.tags_outstanding, bus.axi_ar_ready} !== {1'b0, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL single_after got_valid=%b got_out=%0d got_ready=%b required=0/1/1", bus.tlp_h_valid, bus.tags_outstanding, bus.axi_ar_ready);
    end
    free_all();
  endtask

  task automatic test_back_to_back();
    bus.tlp_h_ready = 1'b1;
    send_cmd(32'h0, 8'd255, 4'h2, 3'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {1'b1, 30'(i * 32), 10'd32, 3'(i), 4'h2, (i == 7)};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL b2b_hdr%0d got=%h required=%h", i, got, exp); end
    end
    tick();
    bus.tlp_h_ready = 1'b0;
    checks++;
    if ({bus.tlp_h_valid, bus.tags_outstanding} !== {1'b0, 4'd8}) begin
      failures++;
      $display("FAIL b2b_done got_valid=%b got_out=%0d required=0/8", bus.tlp_h_valid, bus.tags_outstanding);
    end
    free_all();
    checks++;
    if (bus.tags_outstanding !== 4'd0) begin failures++; $display("FAIL b2b_freed got=%0d required=0", bus.tags_outstanding); end
  endtask

  task automatic test_split_4k();
    bus.tlp_h_ready = 1'b1;
    send_cmd(32'hFF0, 8'd7, 4'h3, 3'd2);
    tick();
    exp = {1'b1, 30'h3FC, 10'd4, 3'd0, 4'h3, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL split4k_hdr0 got=%h required=%h", got, exp); end
    tick();
    exp = {1'b1, 30'h400, 10'd4, 3'd1, 4'h3, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL split4k_hdr1 got=%h required=%h", got, exp); end
    tick();
    bus.tlp_h_ready = 1'b0;
    free_all();
  endtask

  task automatic test_tag_exhaust();
    bus.tlp_h_ready = 1'b1;
    send_cmd(32'hFC0, 8'd255, 4'h5, 3'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) exp = {1'b1, 30'h3F0, 10'd16, 3'd0, 4'h5, 1'b0};
      else        exp = {1'b1, 30'(32'h400 + (i - 1) * 32), 10'd32, 3'(i), 4'h5, 1'b0};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL exhaust_hdr%0d got=%h required=%h", i, got, exp); end
    end
    tick();
    tick();
    tick();
    checks++;
    if ({bus.tlp_h_valid, bus.tags_outstanding} !== {1'b0, 4'd8}) begin
      failures++;
      $display("FAIL exhaust_stall got_valid=%b got_out=%0d required=0/8", bus.tlp_h_valid, bus.tags_outstanding);
    end
    bus.tag_free_valid = 1'b1;
    bus.tag_free = 3'd3;
    tick();
    bus.tag_free_valid = 1'b0;
    checks++;
    if ({bus.tlp_h_valid, bus.tags_outstanding} !== {1'b0, 4'd7}) begin
      failures++;
      $display("FAIL exhaust_freed got_valid=%b got_out=%0d required=0/7", bus.tlp_h_valid, bus.tags_outstanding);
    end
    tick();
    exp = {1'b1, 30'h4E0, 10'd16, 3'd3, 4'h5, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL exhaust_hdr8 got=%h required=%h", got, exp); end
    tick();
    bus.tlp_h_ready = 1'b0;
    checks++;
    if ({bus.tlp_h_valid, bus.axi_ar_ready} !== 2'b01) begin
      failures++;
      $display("FAIL exhaust_end got_valid=%b got_ready=%b required=0/1", bus.tlp_h_valid, bus.axi_ar_ready);
    end
    free_all();
  endtask

  task automatic test_hold();
    bus.tlp_h_ready = 1'b0;
    send_cmd(32'h2000, 8'd63, 4'h6, 3'd0);
    bus.max_read_request = 3'd5;
    tick();
    exp = {1'b1, 30'h800, 10'd32, 3'd0, 4'h6, 1'b0};
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (got !== exp) begin failures++; $display("FAIL hold_cycle%0d got=%h required=%h", c, got, exp); end
      if (c == 2) begin
        bus.tag_free_valid = 1'b1;
        bus.tag_free = 3'd5;
      end
      tick();
      bus.tag_free_valid = 1'b0;
    end
    checks++;
    if (bus.tags_outstanding !== 4'd1) begin failures++; $display("FAIL hold_bad_free got=%0d required=1", bus.tags_outstanding); end
    bus.tlp_h_ready = 1'b1;
    tick();
    exp = {1'b1, 30'h820, 10'd32, 3'd1, 4'h6, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL hold_mrr_latched got=%h required=%h", got, exp); end
    tick();
    bus.tlp_h_ready = 1'b0;
    bus.max_read_request = 3'd0;
    free_all();
  endtask

  task automatic test_reset_mid();
    bus.tlp_h_ready = 1'b1;
    send_cmd(32'h0, 8'd255, 4'h7, 3'd0);
    tick();
    tick();
    tick();
    tick();
    bus.tlp_h_ready = 1'b0;
    checks++;
    if (bus.tags_outstanding !== 4'd4) begin failures++; $display("FAIL mid_pre_out got=%0d required=4", bus.tags_outstanding); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.tlp_h_valid, bus.tags_outstanding, bus.axi_ar_ready} !== {1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset got_valid=%b got_out=%0d got_ready=%b required=0/0/0", bus.tlp_h_valid, bus.tags_outstanding, bus.axi_ar_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.axi_ar_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready got=%b required=1", bus.axi_ar_ready); end
    bus.tlp_h_ready = 1'b1;
    send_cmd(32'h100, 8'd0, 4'h8, 3'd0);
    tick();
    exp = {1'b1, 30'h40, 10'd1, 3'd0, 4'h8, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_after_hdr got=%h required=%h", got, exp); end
    tick();
    bus.tlp_h_ready = 1'b0;
    free_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_split_4k();
    test_tag_exhaust();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dlsc_pcie_outbound_read_req_tagged.md
Name: dlsc_pcie_outbound_read_req_tagged

Overview:
- Successor read-request generator for the PCIe outbound path.
- Takes AXI4 read commands with up to 256 beats, plus an AXI ID, and splits each into Memory Read TLP headers.
- Split sizes are bounded by max_read_request, MAX_SIZE and 4KB address boundaries.
- Each header gets a PCIe tag from a bounded free pool; the completion path returns tags, which limits outstanding non-posted reads.

Parameters:
- ADDR, 32, address width in bytes (bits ADDR-1:2 carried).
- LEN, 8, AXI length width (beats = axi_ar_len+1; 1 beat = 1 DW).
- ID, 4, AXI ID width, passed through per TLP.
- TAGS, 8, number of tags; power of 2, range 2..32.
- TAGB, log2(TAGS), tag index width (derived, not overridable).
- MAX_SIZE, 512, maximum read request size in bytes (128..4096).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- axi_ar_ready  out  1  command accept.
- axi_ar_valid  in  1  command valid.
- axi_ar_addr  in  ADDR  byte address; bits 1:0 ignored.
- axi_ar_len  in  LEN  beats-1.
- axi_ar_id  in  ID  AXI ID.
- max_read_request  in  3  0..5 = 128..4096 B; 6 and 7 treated as 128 B.
- tlp_h_ready  in  1  header consumer ready.
- tlp_h_valid  out  1  header valid.
- tlp_h_addr  out  ADDR-2  DW address.
- tlp_h_len  out  10  DW length; 0 encodes 1024.
- tlp_h_tag  out  TAGB  allocated tag.
- tlp_h_id  out  ID  AXI ID of the parent command.
- tlp_h_last  out  1  final TLP of the parent command.
- tag_free_valid  in  1  completion path returns a tag.
- tag_free  in  TAGB  tag being returned.
- tags_outstanding  out  TAGB+1  count of allocated tags.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - axi_ar_ready=0, tlp_h_valid=0, tags_outstanding=0.
  - All tags free, FSM to IDLE.
  - tlp_h_addr, tlp_h_len, tlp_h_tag, tlp_h_id and tlp_h_last are don't-care.
  - A reset mid-command drops the remaining pieces and frees every tag.
- FSM states:
  - IDLE: axi_ar_ready=1 (registered). On ar handshake, capture addr, len_dw=len+1 (11-bit), id, max_len; go to SPLIT. axi_ar_ready drops the next cycle.
  - SPLIT: axi_ar_ready=0. Emits pieces until remaining=0, then returns to IDLE. axi_ar_ready=1 on the cycle after the last header handshake.
- max_len:
  - min(128<<max_read_request, MAX_SIZE)/4 DW.
  - Latched at command accept; a change mid-command has no effect until the next command.
- Piece length:
  - piece = min(remaining, max_len, 1024-addr[11:2]), so a TLP never crosses a 4KB boundary.
  - After each piece: addr += piece (full-width add), remaining -= piece.
  - tlp_h_last=1 when piece==remaining.
- Header load:
  - In SPLIT, with the header register empty (or being emptied the same cycle) and at least one tag free, the next piece loads into the tlp_h_* registers and tlp_h_valid=1.
  - Earliest tlp_h_valid is the cycle after the ar handshake (1-cycle latency).
  - The tag is the lowest-index free tag and is marked allocated on load.
  - With back-to-back tlp_h_ready=1 and tags available, one header issues per cycle.
- Header hold: while tlp_h_valid=1 and tlp_h_ready=0, all tlp_h_* outputs are held stable.
- Tag exhaustion: with no free tag, tlp_h_valid stays 0 and nothing is consumed; the piece issues on the cycle after a tag is freed.
- Tag free:
  - tag_free_valid with an allocated tag clears it; the tag is usable from the next cycle.
  - Freeing an unallocated tag is ignored and leaves the count unchanged.
  - Simultaneous allocate and free of different tags: count unchanged.
  - Free and allocate never target the same tag in one cycle, because allocation sees only the registered free map.
- tags_outstanding always equals the popcount of the allocated map; its maximum value is TAGS.
- Lengths: len_dw max 256 with LEN=8. With LEN up to 10, len_dw=1024 yields tlp_h_len=0 when piece=1024.

Test Plan:
- addr=0x1000, len=31, mrr=0 (128 B) -> one header: addr_dw=0x400, len=32, tag=0, last=1; ar accept to valid in 1 cycle.
- addr=0x0, len=255, mrr=0, tlp_h_ready=1 -> 8 headers of 32 DW on consecutive cycles: tags 0..7, addrs 0x000,0x020,...,0x0E0 (DW); last only on the 8th.
- addr=0xFF0, len=7, mrr=2 -> two headers: (0x3FC, len 4, last=0) and (0x400, len 4, last=1), split at the 4KB boundary.
- TAGS=8, no frees, command len=255 with mrr=0 plus a 9th piece pending -> after 8 headers tlp_h_valid=0 and tags_outstanding=8. Free tag 3 -> the next header carries tag 3 one cycle later.
- tlp_h_ready held 0 for 5 cycles -> addr, len, tag, id and last stable. Same test also covers: mrr changed mid-command has no effect; free of an unallocated tag leaves the count unchanged.
- rst_n=0 mid-command with 4 tags outstanding -> next cycle tlp_h_valid=0, tags_outstanding=0, axi_ar_ready=0. After release, axi_ar_ready=1 and the next header uses tag 0.
